// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared definitions for the MMIO bus controller.
//   state_e    : controller FSM encoding (IDLE=0, ACCESS=1, RESP=2)
//   WAIT_W     : width of one wait-state field / the wait counter
//   field_get  : extracts field idx of width w from a packed parameter vector
package mmio_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int WAIT_W    = 4;
  localparam int PACK_MAX  = 1024;
  localparam int FIELD_MAX = 64;

  // Packed parameters are zero-extended to PACK_MAX bits by the caller so a
  // single function serves every field width; the result is truncated back.
  function automatic logic [FIELD_MAX-1:0] field_get(input logic [PACK_MAX-1:0] vec,
                                                     input int idx,
                                                     input int w);
    logic [PACK_MAX-1:0] sh;
    sh = vec >> (idx * w);
    return FIELD_MAX'(sh & ((PACK_MAX'(1) << w) - PACK_MAX'(1)));
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// CPU-side handshake and channel-side bus of the MMIO bus controller.
//   master : CPU / channel side (drives req, we, mmio, addr, din, s_rdata)
//   slave  : the controller (drives dout, ready, err, err_addr, s_*)
interface mmio_bus_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_MMIO     = 2
);
  logic                           req;
  logic                           we;
  logic                           mmio;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [DATA_WIDTH-1:0]          din;
  logic [DATA_WIDTH-1:0]          dout;
  logic                           ready;
  logic                           err;
  logic [ADDR_WIDTH-1:0]          err_addr;
  logic [N_MMIO:0]                s_sel;
  logic                           s_we;
  logic [ADDR_WIDTH-1:0]          s_addr;
  logic [DATA_WIDTH-1:0]          s_wdata;
  logic [(N_MMIO+1)*DATA_WIDTH-1:0] s_rdata;

  modport master (
    output req, we, mmio, addr, din, s_rdata,
    input  dout, ready, err, err_addr, s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    input  req, we, mmio, addr, din, s_rdata,
    output dout, ready, err, err_addr, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask decode of the MMIO peripheral channels.
//   addr : address to decode
//   hit  : one-hot, bit i set for the lowest-index peripheral i that matches
//          (peripheral i is controller channel i+1)
//   miss : no peripheral matches
module mmio_addr_decode
  import mmio_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int N_MMIO     = 2,
  parameter logic [N_MMIO*ADDR_WIDTH-1:0] MMIO_BASE = {8'h10, 8'h00},
  parameter logic [N_MMIO*ADDR_WIDTH-1:0] MMIO_MASK = {8'hFF, 8'hF0}
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [N_MMIO-1:0]     hit,
  output logic                  miss
);

  localparam logic [PACK_MAX-1:0] BASE_EXT = PACK_MAX'(MMIO_BASE);
  localparam logic [PACK_MAX-1:0] MASK_EXT = PACK_MAX'(MMIO_MASK);

  always_comb begin
    logic                  found;
    logic [ADDR_WIDTH-1:0] base_i;
    logic [ADDR_WIDTH-1:0] mask_i;
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < N_MMIO; i++) begin
      base_i = ADDR_WIDTH'(field_get(BASE_EXT, i, ADDR_WIDTH));
      mask_i = ADDR_WIDTH'(field_get(MASK_EXT, i, ADDR_WIDTH));
      // Overlapping windows resolve to the lowest index.
      if (!found && ((addr & mask_i) == (base_i & mask_i))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Memory/MMIO bus controller: CPU data port to one RAM channel (channel 0)
// and N_MMIO peripheral channels (1..N_MMIO), with req/ready handshake,
// per-channel wait states, registered read data and unmapped-access error.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : controller side of mmio_bus_ctrl_if (CPU request/response and
//         channel select/strobe/address/write data/read data)
module mmio_bus_ctrl
  import mmio_bus_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_MMIO     = 2,
  parameter logic [N_MMIO*ADDR_WIDTH-1:0]  MMIO_BASE   = {8'h10, 8'h00},
  parameter logic [N_MMIO*ADDR_WIDTH-1:0]  MMIO_MASK   = {8'hFF, 8'hF0},
  parameter logic [(N_MMIO+1)*WAIT_W-1:0]  WAIT_STATES = '0
) (
  input logic          clk,
  input logic          rst,
  mmio_bus_ctrl_if.slave bus
);

  localparam logic [PACK_MAX-1:0] WAIT_EXT = PACK_MAX'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [N_MMIO:0]       s_sel_q, s_sel_d;
  logic                  s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;

  logic [N_MMIO-1:0]     hit;
  logic                  miss;
  logic [N_MMIO:0]       sel_dec;
  logic [WAIT_W-1:0]     wait_sel;
  logic [DATA_WIDTH-1:0] rd_mux;

  mmio_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_MMIO     (N_MMIO),
    .MMIO_BASE  (MMIO_BASE),
    .MMIO_MASK  (MMIO_MASK)
  ) u_decode (
    .addr (bus.addr),
    .hit  (hit),
    .miss (miss)
  );

  assign sel_dec = bus.mmio ? {hit, 1'b0} : {{N_MMIO{1'b0}}, 1'b1};

  always_comb begin
    wait_sel = '0;
    for (int c = 0; c <= N_MMIO; c++) begin
      if (sel_dec[c]) wait_sel = WAIT_W'(field_get(WAIT_EXT, c, WAIT_W));
    end
  end

  // s_sel_q is one-hot and held for the whole access, so it steers the mux.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c <= N_MMIO; c++) begin
      if (s_sel_q[c]) rd_mux = rd_mux | bus.s_rdata[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    dout_d     = dout_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    s_sel_d    = s_sel_q;
    s_we_d     = 1'b0;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d      = bus.we;
          s_addr_d  = bus.addr;
          s_wdata_d = bus.din;
          if (!bus.mmio || !miss) begin
            s_sel_d = sel_dec;
            cnt_d   = wait_sel;
            // Outputs are registered: the strobe is set on the edge that
            // begins the final ACCESS cycle, here when there are no waits.
            s_we_d  = bus.we && (wait_sel == '0);
            state_d = ST_ACCESS;
          end else begin
            err_addr_d = bus.addr;
            err_d      = 1'b1;
            ready_d    = 1'b1;
            dout_d     = '0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          s_sel_d = '0;
          ready_d = 1'b1;
          dout_d  = we_q ? '0 : rd_mux;
          state_d = ST_RESP;
        end else begin
          cnt_d  = cnt_q - WAIT_W'(1);
          s_we_d = we_q && (cnt_q == WAIT_W'(1));
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        s_sel_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      s_sel_q    <= '0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      s_sel_q    <= s_sel_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.s_sel    = s_sel_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;

endmodule
